// File: rtl/wb_interconnect_pkg.sv
// wb_interconnect_pkg
// Shared types and constants for the Wishbone 1-master/N-slave interconnect.
//   state_t   : interconnect FSM states
//   ERR_DATA  : read data returned on any error completion
//   selWidth  : width of a slave index (never less than 1 bit)
package wb_interconnect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    DONE,
    DECERR,
    TOERR
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  function automatic int selWidth(input int numSlaves);
    return (numSlaves > 1) ? $clog2(numSlaves) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// wb_addr_decoder
// Combinational priority address decoder. Slave i matches when
// (addr & mask[i]) == base[i]; the lowest matching index wins.
// Ports:
//   i_addr : master address
//   o_hit  : at least one slave matches
//   o_sel  : index of the winning slave (0 when no hit)
module wb_addr_decoder
  import wb_interconnect_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_W      = selWidth(NUM_SLAVES),
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_hit,
  output logic [SEL_W-1:0]      o_sel
);

  // Scan from the highest index down so the lowest matching slave is the
  // last assignment and therefore wins.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        o_hit = 1'b1;
        o_sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// wb_interconnect
// Wishbone classic 1-master/N-slave interconnect. Each master cycle is
// decoded against a base/mask table, the request is registered toward the
// selected slave, and its ack/data are returned. Unmapped addresses, and
// optionally stalled slaves, complete with an error response.
// Optional feature macro: WB_INTERCONNECT_TIMEOUT_EN (slave timeout -> TOERR).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cyc_i/stb_i/we_i      : master cycle, strobe, write enable
//   addr_i/data_i         : master address and write data
//   data_o/ack_o/err_o    : registered read data, ack, error to master
//   s_cyc_o/s_stb_o       : per-slave cycle/strobe (one-hot while busy)
//   s_we_o/s_addr_o/s_data_o : broadcast write enable, address, write data
//   s_data_i/s_ack_i      : packed slave read data, slave acks
//   fault_o/fault_addr_o  : error pulse and address of the last faulting cycle
module wb_interconnect
  import wb_interconnect_pkg::*;
#(
  parameter int NUM_SLAVES     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cyc_i,
  input  logic                             stb_i,
  input  logic                             we_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             ack_o,
  output logic                             err_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  output logic                             s_we_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic [DATA_WIDTH-1:0]            s_data_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  output logic                             fault_o,
  output logic [ADDR_WIDTH-1:0]            fault_addr_o
);

  localparam int SEL_W = selWidth(NUM_SLAVES);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

  logic                  w_hit;
  logic [SEL_W-1:0]      w_sel;
  logic [NUM_SLAVES-1:0] w_selOh;
  logic                  w_selAck;
  logic [DATA_WIDTH-1:0] w_selData;

  state_t                r_state;
  logic [NUM_SLAVES-1:0] r_sCyc;
  logic [NUM_SLAVES-1:0] r_sStb;
  logic                  r_sWe;
  logic [ADDR_WIDTH-1:0] r_sAddr;
  logic [DATA_WIDTH-1:0] r_sData;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_fault;
  logic [ADDR_WIDTH-1:0] r_faultAddr;

`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_toCnt;
  logic             w_expired;

  // The counter holds the number of BUSY cycles already completed, so at the
  // edge closing the last allowed cycle it reads TIMEOUT_CYCLES-1.
  assign w_expired = (r_toCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  wb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_W      (SEL_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .i_addr (addr_i),
    .o_hit  (w_hit),
    .o_sel  (w_sel)
  );

  always_comb begin
    w_selOh = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_selOh[i] = w_hit && (w_sel == SEL_W'(i));
    end
  end

  // r_sCyc is one-hot on the selected slave while BUSY and zero otherwise,
  // so it doubles as the response mux select and masks unselected acks.
  always_comb begin
    w_selAck  = |(s_ack_i & r_sCyc);
    w_selData = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sCyc[i]) begin
        w_selData = w_selData | s_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Master-side responses are single-cycle pulses: they default low every
  // cycle and are raised only on the edge that enters DONE/DECERR/TOERR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sCyc      <= '0;
      r_sStb      <= '0;
      r_sWe       <= 1'b0;
      r_sAddr     <= '0;
      r_sData     <= '0;
      r_data      <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_fault     <= 1'b0;
      r_faultAddr <= '0;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
      r_toCnt     <= '0;
`endif
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_fault <= 1'b0;
      r_data  <= '0;
      case (r_state)
        IDLE: begin
          if (cyc_i && stb_i) begin
            r_sWe   <= we_i;
            r_sAddr <= addr_i;
            r_sData <= data_i;
            if (w_hit) begin
              r_sCyc  <= w_selOh;
              r_sStb  <= w_selOh;
              r_state <= BUSY;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
              r_toCnt <= '0;
`endif
            end else begin
              r_err       <= 1'b1;
              r_fault     <= 1'b1;
              r_data      <= ERR_WORD;
              r_faultAddr <= addr_i;
              r_state     <= DECERR;
            end
          end
        end
        BUSY: begin
`ifdef WB_INTERCONNECT_TIMEOUT_EN
          r_toCnt <= r_toCnt + CNT_W'(1);
`endif
          // A master abort takes precedence: it has stopped listening.
          if (!cyc_i) begin
            r_sCyc  <= '0;
            r_sStb  <= '0;
            r_state <= IDLE;
          end else if (w_selAck) begin
            r_sCyc  <= '0;
            r_sStb  <= '0;
            r_ack   <= 1'b1;
            r_data  <= r_sWe ? '0 : w_selData;
            r_state <= DONE;
          end
`ifdef WB_INTERCONNECT_TIMEOUT_EN
          else if (w_expired) begin
            r_sCyc      <= '0;
            r_sStb      <= '0;
            r_err       <= 1'b1;
            r_fault     <= 1'b1;
            r_data      <= ERR_WORD;
            r_faultAddr <= r_sAddr;
            r_state     <= TOERR;
          end
`endif
        end
        // DONE, DECERR and TOERR last exactly one cycle and ignore requests.
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_o       = r_data;
  assign ack_o        = r_ack;
  assign err_o        = r_err;
  assign s_cyc_o      = r_sCyc;
  assign s_stb_o      = r_sStb;
  assign s_we_o       = r_sWe;
  assign s_addr_o     = r_sAddr;
  assign s_data_o     = r_sData;
  assign fault_o      = r_fault;
  assign fault_addr_o = r_faultAddr;

endmodule

// File: tb/tb_wb_interconnect.sv
// tb_wb_interconnect
// Randomized scoreboard bench for wb_interconnect with a 3-slave map:
//   slave0 base 0x0000_0000 mask 0x8000_0000
//   slave1 base 0x8000_0000 mask 0xFFFF_F000
//   slave2 base 0x8000_0000 mask 0xF000_0000 (overlaps slave1, lower wins)
// Timeout cases are exercised when WB_INTERCONNECT_TIMEOUT_EN is defined.
module tb_wb_interconnect;

  localparam int NS = 3;
  localparam int TO = 8;

  typedef struct {
    bit          isErr;
    logic [31:0] data;
    logic [31:0] faultAddr;
    int          cycle;
  } expResp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cyc_i, stb_i, we_i;
  logic [31:0]    addr_i, data_i;
  logic [31:0]    data_o;
  logic           ack_o, err_o;
  logic [NS-1:0]  s_cyc_o, s_stb_o;
  logic           s_we_o;
  logic [31:0]    s_addr_o, s_data_o;
  logic [NS*32-1:0] s_data_i;
  logic [NS-1:0]  s_ack_i;
  logic           fault_o;
  logic [31:0]    fault_addr_o;

  int vectors = 0;
  int miscompares = 0;
  int cycleNum = 0;
  expResp_t expQ[$];
  expResp_t monE;

  logic [31:0] baseTab [NS] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] maskTab [NS] = '{32'h8000_0000, 32'hFFFF_F000, 32'hF000_0000};

  wb_interconnect #(
    .NUM_SLAVES     (NS),
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .SLAVE_BASE     ({32'h8000_0000, 32'h8000_0000, 32'h0000_0000}),
    .SLAVE_MASK     ({32'hF000_0000, 32'hFFFF_F000, 32'h8000_0000}),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cyc_i        (cyc_i),
    .stb_i        (stb_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .s_cyc_o      (s_cyc_o),
    .s_stb_o      (s_stb_o),
    .s_we_o       (s_we_o),
    .s_addr_o     (s_addr_o),
    .s_data_o     (s_data_o),
    .s_data_i     (s_data_i),
    .s_ack_i      (s_ack_i),
    .fault_o      (fault_o),
    .fault_addr_o (fault_addr_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual,
               expected, cycleNum);
    end
  endtask

  // Reference address map: first table entry whose masked address equals
  // its base, or -1 when nothing matches.
  function automatic int refDecode(input logic [31:0] addr);
    for (int i = 0; i < NS; i++) begin
      if ((addr & maskTab[i]) == baseTab[i]) return i;
    end
    return -1;
  endfunction

  // delay 0 means the slave never acks.
  function automatic bit timesOut(input int delay);
`ifdef WB_INTERCONNECT_TIMEOUT_EN
    return (delay == 0) || (delay > TO);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every master-side response is matched against the scoreboard.
  always @(negedge clk) begin
    if (ack_o || err_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResp", {62'b0, ack_o, err_o}, 64'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("ackErrExclusive", {63'b0, ack_o && err_o}, 64'd0);
        checkOutput("respErr", {63'b0, err_o}, {63'b0, monE.isErr});
        checkOutput("respAck", {63'b0, ack_o}, {63'b0, !monE.isErr});
        checkOutput("respFault", {63'b0, fault_o}, {63'b0, monE.isErr});
        checkOutput("respData", {32'b0, data_o}, {32'b0, monE.data});
        checkOutput("respCycle", 64'(cycleNum), 64'(monE.cycle));
        if (monE.isErr) begin
          checkOutput("faultAddr", {32'b0, fault_addr_o}, {32'b0, monE.faultAddr});
        end
      end
    end else if (fault_o) begin
      checkOutput("faultWithoutErr", {63'b0, fault_o}, 64'd0);
    end
  end

  // One master transaction plus the addressed slave's behaviour. Called at a
  // negedge; b2b means the previous response is being shown right now, so
  // this request is held through the one-cycle response state first.
  task automatic applyStimulus(input logic [31:0] addr, input logic we,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int delay, input int abortAt, input bit b2b);
    int m, idx, j, lastBusy;
    bit finished;
    expResp_t e;
    logic [NS-1:0] one, oh;
    one = 1;
    m = cycleNum + (b2b ? 1 : 0);
    idx = refDecode(addr);
    oh = (idx >= 0) ? (one << idx) : '0;
    if (idx < 0) lastBusy = 0;
    else if (abortAt > 0) lastBusy = abortAt;
    else if (timesOut(delay)) lastBusy = TO;
    else lastBusy = delay;
    cyc_i = 1'b1; stb_i = 1'b1; addr_i = addr; we_i = we; data_i = wdata;
    if (abortAt == 0) begin
      e.isErr = (idx < 0) || timesOut(delay);
      e.data = e.isErr ? 32'hDEAD_BEEF : (we ? 32'h0 : rdata);
      e.faultAddr = addr;
      e.cycle = m + lastBusy + 1;
      expQ.push_back(e);
    end
    finished = 1'b0;
    while (!finished) begin
      @(negedge clk);
      j = cycleNum - m;
      s_ack_i = '0;
      if (j >= 1) begin
        if (j <= lastBusy) begin
          checkOutput("sCyc", {61'b0, s_cyc_o}, {61'b0, oh});
          checkOutput("sStb", {61'b0, s_stb_o}, {61'b0, oh});
          if (j == 1) begin
            checkOutput("sWe", {63'b0, s_we_o}, {63'b0, we});
            checkOutput("sAddr", {32'b0, s_addr_o}, {32'b0, addr});
            checkOutput("sData", {32'b0, s_data_o}, {32'b0, wdata});
          end
          s_ack_i = NS'($urandom) & ~oh;
          s_data_i = {$urandom, $urandom, $urandom};
          s_data_i[idx*32 +: 32] = rdata;
          if (abortAt == 0 && j == delay) s_ack_i = s_ack_i | oh;
          if (abortAt > 0 && j == abortAt) begin
            cyc_i = 1'b0; stb_i = 1'b0;
          end
        end else begin
          if (j == lastBusy + 1) begin
            checkOutput("sCycDrop", {61'b0, s_cyc_o}, 64'd0);
            checkOutput("sStbDrop", {61'b0, s_stb_o}, 64'd0);
          end
          if (abortAt > 0) begin
            checkOutput("abortNoResp", {62'b0, ack_o, err_o}, 64'd0);
            finished = 1'b1;
          end else if (ack_o || err_o) begin
            finished = 1'b1;
          end else if (j > lastBusy + 20) begin
            checkOutput("respMissing", 64'd0, 64'd1);
            if (expQ.size() > 0) void'(expQ.pop_front());
            finished = 1'b1;
          end
        end
      end
    end
  endtask

  // Drop the master request for one cycle; the last response must be gone.
  task automatic idleGap();
    cyc_i = 1'b0; stb_i = 1'b0; s_ack_i = '0;
    @(negedge clk);
    checkOutput("respOneCycle", {62'b0, ack_o, err_o}, 64'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_sCyc"}, {61'b0, s_cyc_o}, 64'd0);
    checkOutput({tag, "_sStb"}, {61'b0, s_stb_o}, 64'd0);
    checkOutput({tag, "_ackErrFault"}, {61'b0, ack_o, err_o, fault_o}, 64'd0);
    checkOutput({tag, "_dataO"}, {32'b0, data_o}, 64'd0);
    checkOutput({tag, "_faultAddr"}, {32'b0, fault_addr_o}, 64'd0);
    checkOutput({tag, "_sBcast"}, {31'b0, s_we_o, s_addr_o}, 64'd0);
  endtask

  // Reset asserted while a slave is being waited on.
  task automatic resetInBusy(input logic [31:0] addr);
    int idx;
    logic [NS-1:0] one;
    one = 1;
    idx = refDecode(addr);
    cyc_i = 1'b1; stb_i = 1'b1; addr_i = addr; we_i = 1'b0; data_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy_sCyc", {61'b0, s_cyc_o}, {61'b0, one << idx});
    rst_n = 1'b0;
    @(negedge clk);
    checkAllZero("rstBusy");
    rst_n = 1'b1; cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk);
    checkOutput("rstBusyIdle_sCyc", {61'b0, s_cyc_o}, 64'd0);
  endtask

  initial begin
    logic [31:0] addr, wdata, rdata;
    logic we;
    int delay, abortAt, idx;
    bit prevResp, b2b;

    rst_n = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    addr_i = '0; data_i = '0; s_data_i = '0; s_ack_i = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed transactions");
    applyStimulus(32'h0000_0010, 1'b0, 32'h0, 32'h1234_5678, 1, 0, 1'b0);
    idleGap();
    applyStimulus(32'h8000_0004, 1'b1, 32'h0000_00A5, 32'h5555_5555, 4, 0, 1'b0);
    idleGap();
    applyStimulus(32'h9000_0000, 1'b0, 32'h0, 32'h0, 1, 0, 1'b0);
    idleGap();
    applyStimulus(32'h8123_4560, 1'b0, 32'h0, 32'h0BAD_F00D, 2, 0, 1'b0);
    applyStimulus(32'h8000_0FFC, 1'b0, 32'h0, 32'h7777_1111, 1, 0, 1'b1);
    idleGap();
`ifdef WB_INTERCONNECT_TIMEOUT_EN
    applyStimulus(32'h0000_0020, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);
    idleGap();
    applyStimulus(32'h0000_0024, 1'b0, 32'h0, 32'hCAFE_F00D, TO, 0, 1'b0);
    idleGap();
`endif
    applyStimulus(32'h0000_0100, 1'b0, 32'h0, 32'h1, 5, 2, 1'b0);
    idleGap();

    $display("[TB] randomized transactions");
    prevResp = 1'b0;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: addr = $urandom & 32'h7FFF_FFFF;
        1: addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
        2: addr = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
        default: addr = {4'($urandom_range(9, 15)), 28'($urandom)};
      endcase
      we = 1'($urandom_range(0, 1));
      wdata = $urandom;
      rdata = $urandom;
      delay = $urandom_range(1, 6);
`ifdef WB_INTERCONNECT_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0) delay = 0;
`endif
      idx = refDecode(addr);
      abortAt = 0;
      if (idx >= 0 && delay >= 2 && $urandom_range(0, 7) == 0)
        abortAt = $urandom_range(1, delay - 1);
      b2b = prevResp && ($urandom_range(0, 2) == 0);
      if (!b2b) idleGap();
      applyStimulus(addr, we, wdata, rdata, delay, abortAt, b2b);
      prevResp = (abortAt == 0);
    end
    idleGap();

    $display("[TB] reset during busy");
    applyStimulus(32'hA000_0000, 1'b0, 32'h0, 32'h0, 1, 0, 1'b0);
    idleGap();
    resetInBusy(32'h0000_0040);
    applyStimulus(32'h0000_0044, 1'b0, 32'h0, 32'h4444_0000, 3, 0, 1'b0);
    idleGap();

    repeat (3) @(negedge clk);
    checkOutput("pendingResp", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_interconnect.md
# wb_interconnect

Parametrised Wishbone classic 1-master/N-slave interconnect replacing the fixed bit-31 memory/peripheral split and the fixed 8-port peripheral bus in the SoC top. It decodes each master cycle against a per-slave base/mask table and registers the selected request toward one slave. It returns that slave's ack and data, or an error response on unmapped addresses and (optionally) on slave timeout. It sits between `Grande_Risco5` and all memory/peripheral slaves.

## Interface
Parameters:
- `NUM_SLAVES`, 8: number of slave ports (1..16)
- `DATA_WIDTH`, 32: data bus width
- `ADDR_WIDTH`, 32: address bus width
- `SLAVE_BASE`, `{NUM_SLAVES{32'h0}}`: packed array of base addresses, slave i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `SLAVE_MASK`, `{NUM_SLAVES{32'h0}}`: packed array of match masks, same layout
- `TIMEOUT_CYCLES`, 1024: wait cycles before a timeout error (≥2)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `cyc_i`, `stb_i`, `we_i` in 1 each: master cycle, strobe, write enable
- `addr_i` in ADDR_WIDTH: master address
- `data_i` in DATA_WIDTH: master write data
- `data_o` out DATA_WIDTH: read data to master
- `ack_o` out 1: successful completion
- `err_o` out 1: error completion
- `s_cyc_o`, `s_stb_o` out NUM_SLAVES: per-slave cycle and strobe
- `s_we_o` out 1: write enable, broadcast
- `s_addr_o` out ADDR_WIDTH: address, broadcast
- `s_data_o` out DATA_WIDTH: write data, broadcast
- `s_data_i` in NUM_SLAVES*DATA_WIDTH: packed slave read data
- `s_ack_i` in NUM_SLAVES: slave acks
- `fault_o` out 1: one-cycle pulse on any error completion
- `fault_addr_o` out ADDR_WIDTH: address of the most recent faulting cycle

## Operation
- Match rule: slave i hits when `(addr_i & SLAVE_MASK[i]) == SLAVE_BASE[i]`. If several slaves hit, the lowest index wins.
- FSM states:
  - IDLE → on `cyc_i & stb_i`: latch `sel`, `addr_i`, `we_i` and `data_i` into the s_* registers. Go to BUSY on a hit, DECERR on a miss.
  - BUSY: assert `s_cyc_o[sel]` and `s_stb_o[sel]`; all other bits are 0.
    - `s_ack_i[sel]` → capture `s_data_i[sel]`, go to DONE.
    - `cyc_i` low (abort) → go to IDLE with no ack or err.
    - Timeout (see Configuration) → go to TOERR.
    - Acks from unselected slaves are ignored.
  - DONE: `ack_o`=1 and `data_o`=captured data for one cycle, then go to IDLE.
  - DECERR / TOERR: `err_o`=1, `fault_o`=1, `data_o`=`ERR_DATA` (32'hDEAD_BEEF truncated to DATA_WIDTH), `fault_addr_o` updated, for one cycle. Then go to IDLE.
- Write cycles complete through DONE with `data_o`=0.
- `ack_o` and `err_o` are never high together.
- Back-to-back requests are accepted in IDLE only; requests seen in DONE or the error states are ignored.

## Timing
- Reset values: all outputs 0, including `fault_addr_o`; FSM in IDLE; timeout counter 0. Reset mid-transaction drops `s_cyc_o` and `s_stb_o` on the next edge and returns no ack.
- Latency: request sampled at edge 0, `s_stb_o` high in cycle 1. Slave ack in cycle k → `ack_o` in cycle k+1. With a zero-wait slave (ack in cycle 1) `ack_o` is high in cycle 2.
- Unmapped address: `err_o` in cycle 1.
- `s_*` outputs are registered. `data_o`, `ack_o` and `err_o` are registered.

## Configuration
- `WB_INTERCONNECT_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES)+1` clears on entry to BUSY and increments every BUSY cycle.
  - When it reaches `TIMEOUT_CYCLES` without an ack, the FSM goes to TOERR. `s_cyc_o` and `s_stb_o` drop on that same edge.
  - An ack arriving on the expiry cycle wins, so the FSM goes to DONE.
- Undefined: no counter and no TOERR state; BUSY waits indefinitely. Decode errors are still reported.

## Structure
- `wb_interconnect_pkg`: FSM state enum (IDLE, BUSY, DONE, DECERR, TOERR) and the `ERR_DATA` constant.
- Sub-module `wb_addr_decoder`: combinational priority decoder. Outputs `hit` and `sel` index (`$clog2(NUM_SLAVES)` bits, minimum 1).
- The top holds the FSM, the registers and the timeout counter.

## Test plan
- Map: slave0 base 0x0000_0000, mask 0x8000_0000; slave1 base 0x8000_0000, mask 0xFFFF_F000.
- Read 0x0000_0010, slave0 acks in cycle 1 with 0x1234_5678 → `ack_o` in cycle 2, `data_o`=0x1234_5678, `s_stb_o`=2'b01.
- Write 0x8000_0004 with data 0xA5, slave1 waits 3 cycles → `s_data_o`=0xA5, `s_we_o`=1, `ack_o` exactly one cycle, 4 cycles after the request.
- Read 0x9000_0000 (unmapped) → `err_o` and `fault_o` in cycle 1, `data_o`=0xDEAD_BEEF, `fault_addr_o`=0x9000_0000, no `s_stb_o`.
- With the macro defined and TIMEOUT_CYCLES=8, slave0 never acks → `err_o` after 8 BUSY cycles, `s_cyc_o` cleared. Repeat with the ack arriving on cycle 8 → `ack_o`, no `err_o`.
- Drop `cyc_i` in BUSY, and separately pulse `rst_n` low in BUSY → `s_cyc_o`=0 next cycle, no `ack_o` or `err_o`, FSM back in IDLE.
